// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants and the
// bit-period divider, used by both the transmitter and the receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam int DATA_BITS  = 8;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   // Clock cycles per line bit, truncated toward zero.
   function automatic int bit_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and wrapping pointers.
// Read data is the head entry, valid whenever empty is low.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; push+pop leaves count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

   // Storage array; contents need no reset, the pointers guard them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: FIFO in front of a bit-serial
// framer. tx_data is registered, one cycle behind the FSM state.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic [7:0]                    tx_din,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx_data,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD);
   localparam int CW      = $clog2(BIT_DIV + 1);
   localparam int BW      = $clog2(DATA_BITS);

   tx_state_e              state;
   tx_state_e              state_nxt;
   logic [CW-1:0]          baud_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic [DATA_BITS-1:0]   fifo_dout;
   logic                   bit_end;
   logic                   push;
   logic                   load;
   logic                   bypass;
   logic                   full;
   logic                   empty;

   assign tx_ready = !full;
   assign push     = tx_valid && tx_ready;
   assign bit_end  = (baud_cnt == CW'(BIT_DIV - 1));
   assign tx_busy  = (state != IDLE) || !empty;

   // A byte pushed on the last stop cycle into an empty buffer goes
   // straight to the shifter, so it never lands in the FIFO.
   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (push && !bypass),
      .pop   (load && !bypass),
      .din   (tx_din),
      .dout  (fifo_dout),
      .count (fifo_cnt),
      .full  (full),
      .empty (empty)
   );

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state, plus the load strobe that pops the next byte.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      bypass    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               load      = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && bit_cnt == BW'(DATA_BITS - 1))
               state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (!empty || push) begin
                  load      = 1'b1;
                  bypass    = empty;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Baud/bit counters, shift register and the registered line.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx_data  <= 1'b1;
      end else begin
         if (load || state == IDLE || bit_end)
            baud_cnt <= '0;
         else
            baud_cnt <= baud_cnt + CW'(1);

         if (load) begin
            shreg   <= bypass ? tx_din : fifo_dout;
            bit_cnt <= '0;
         end else if (state == DATA && bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BW'(1);
         end

         unique case (state)
            IDLE:    tx_data <= 1'b1;
            START:   tx_data <= 1'b0;
            DATA:    tx_data <= shreg[0];
            STOP:    tx_data <= 1'b1;
            default: tx_data <= 1'b1;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8, transmit buffer entries; power of two, at least 2.
REQ-004 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 sys_rst  input  1  reset; synchronous, active-high.
REQ-006 tx_din  input  8  byte to transmit.
REQ-007 tx_valid  input  1  tx_din is valid this cycle.
REQ-008 tx_ready  output  1  buffer can accept a byte this cycle.
REQ-009 tx_data  output  1  serial line, idle high, 8N1, LSB first.
REQ-010 tx_busy  output  1  a frame is on the line, or the buffer is non-empty.
REQ-011 fifo_cnt  output  log2(FIFO_DEPTH)+1  number of bytes currently buffered.

Function
REQ-012 BIT_DIV = CLK_FREQ/BAUD, integer-truncated; this is 434 at the defaults. Each line bit lasts exactly BIT_DIV sys_clk cycles.
REQ-013 A push occurs when tx_valid && tx_ready on a rising edge. tx_din is written on that edge.
REQ-014 tx_ready = (fifo_cnt != FIFO_DEPTH), combinational from registered state.
REQ-015 tx_valid while full: byte dropped, no state change, no error flag. The source must hold its data until tx_ready.
REQ-016 Simultaneous push and pop: both take effect and fifo_cnt is unchanged. This also holds at fifo_cnt == FIFO_DEPTH-1 and at fifo_cnt == 1.
REQ-017 Buffer order is strictly first in, first out. Read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 FSM states are IDLE, START, DATA, STOP.
REQ-019 IDLE with fifo_cnt != 0: pop the head byte into the shift register and enter START on the same edge.
REQ-020 START drives tx_data=0 for BIT_DIV cycles, then enters DATA.
REQ-021 DATA drives shift-register bit 0 for BIT_DIV cycles, then shifts right. Bit counter 0..7; after bit 7, enter STOP.
REQ-022 STOP drives tx_data=1 for BIT_DIV cycles. On its last cycle:
  - if fifo_cnt != 0 (including a byte pushed that same cycle): pop and enter START directly, no idle gap;
  - otherwise enter IDLE.
REQ-023 tx_data is a registered output. Push latency: a push at edge N into an empty, idle block gives the start bit (tx_data=0) from edge N+2.
REQ-024 A frame is exactly 10*BIT_DIV cycles. N back-to-back buffered bytes occupy exactly N*10*BIT_DIV cycles.
REQ-025 The baud counter counts 0..BIT_DIV-1 and wraps. It is cleared on entry to START; it is held at 0 in IDLE.
REQ-026 tx_busy = (state != IDLE) || (fifo_cnt != 0).

Reset
REQ-027 sys_rst high at a rising edge forces: state=IDLE, tx_data=1, baud counter=0, bit counter=0, fifo_cnt=0, pointers=0, tx_ready=1, tx_busy=0.
REQ-028 Reset mid-frame aborts the frame. tx_data returns to 1 on that edge, buffered bytes are discarded, and no partial frame resumes.
REQ-029 While sys_rst is high, pushes are ignored.

Structure
REQ-030 Shared package uart_pkg holds the FSM state encoding, the BIT_DIV computation function, and the frame-length constants (8 data bits, 1 stop bit). The matching receiver uses the same package.
REQ-031 Buffer is one sub-module, sync_fifo (parameterised width/depth, same clock and reset). It provides push, pop, dout, count, full and empty.
REQ-032 Counters and the shift register reside in uart_tx_buf; no further hierarchy.

Verification
REQ-033 Reset, then push 8'h55 once -> tx_data low from push edge+2 for 434 cycles. Bits 1,0,1,0,1,0,1,0 follow at 434 cycles each, then high for 434. tx_busy falls after the stop bit.
REQ-034 Push 8'hA5, 8'h3C on consecutive cycles -> two contiguous frames, 8680 cycles total, no idle cycle between stop and start. Decoded order is A5 then 3C.
REQ-035 Push 9 bytes 8'h00..8'h08 with tx_valid held high -> tx_ready low when 8 bytes are buffered. All 9 bytes are eventually transmitted in order (the 9th is accepted after the first pop); none are dropped or duplicated.
REQ-036 Assert sys_rst for one cycle during data bit 3 of 8'hFF with 3 bytes queued -> tx_data=1, fifo_cnt=0, tx_busy=0 on the next edge. No further frames appear.
REQ-037 With fifo_cnt == FIFO_DEPTH-1 in STOP, push on the pop edge -> fifo_cnt unchanged and the pushed byte is transmitted last.
REQ-038 Loopback bench: a receiver sampling tx_data at 115200 decodes every byte 8'h00..8'hFF exactly once, in order.
